// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider.
// The master side requests runs and divisors; the slave side is the divider.
interface clk_div_prog_if #(
    parameter int DIV_W = 8
);
    logic             en;
    logic [DIV_W-1:0] div_i;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic [DIV_W-1:0] div_cur;
    logic             load_pend;
    logic             err;

    modport master (
        output en, div_i, div_load,
        input  clk_out, tick, div_cur, load_pend, err
    );

    modport slave (
        input  en, div_i, div_load,
        output clk_out, tick, div_cur, load_pend, err
    );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with 50% duty for even and odd N.
// New divisors take effect only at an output-period boundary so clk_out never glitches.
module clk_div_prog #(
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 5
) (
    input  logic           clk,
    input  logic           rstn,
    clk_div_prog_if.slave  bus
);

    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0] CNT_RST  = DIV_W'(DIV_DEFAULT - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);

    generate
        if (DIV_DEFAULT < 2 || DIV_DEFAULT > (2 ** DIV_W) - 1) begin : g_bad_default
            $error("clk_div_prog: DIV_DEFAULT must lie in 2..2^DIV_W-1");
        end
    endgenerate

    logic [DIV_W-1:0] cnt_q,       cnt_d;
    logic [DIV_W-1:0] div_cur_q,   div_cur_d;
    logic [DIV_W-1:0] pend_q,      pend_d;
    logic             load_pend_q, load_pend_d;
    logic             hi_p_q,      hi_p_d;
    logic             hi_n_q,      hi_n_d;
    logic             tick_q,      tick_d;
    logic             err_q,       err_d;

    logic             wrap;
    logic             start;
    logic [DIV_W-1:0] half_d;

    // The terminal count doubles as the parked state, so a stopped divider
    // restarts through exactly the same path as a running wrap.
    always_comb begin
        wrap        = (cnt_q >= (div_cur_q - DIV_ONE));
        start       = wrap & bus.en;

        cnt_d       = cnt_q;
        div_cur_d   = div_cur_q;
        pend_d      = pend_q;
        load_pend_d = load_pend_q;
        tick_d      = 1'b0;
        err_d       = 1'b0;

        if (start) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (load_pend_q) begin
                div_cur_d   = pend_q;
                load_pend_d = 1'b0;
            end
        end else if (!wrap) begin
            cnt_d = cnt_q + DIV_ONE;
        end

        // A load landing on the boundary edge is captured after the apply,
        // so it waits for the following boundary.
        if (bus.div_load) begin
            if (bus.div_i >= DIV_MIN) begin
                pend_d      = bus.div_i;
                load_pend_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        half_d = div_cur_d >> 1;
        hi_p_d = (cnt_d < half_d);
        hi_n_d = rstn & hi_p_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q       <= CNT_RST;
            div_cur_q   <= DIV_RST;
            pend_q      <= DIV_RST;
            load_pend_q <= 1'b0;
            hi_p_q      <= 1'b0;
            tick_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            div_cur_q   <= div_cur_d;
            pend_q      <= pend_d;
            load_pend_q <= load_pend_d;
            hi_p_q      <= hi_p_d;
            tick_q      <= tick_d;
            err_q       <= err_d;
        end
    end

    // Half-cycle delayed copy of the high phase; stretches odd-N high time by 0.5 cycle.
    always_ff @(negedge clk) begin
        hi_n_q <= hi_n_d;
    end

    // hi_n is always 0 across the boundary edge, so the odd mask may change there safely.
    assign bus.clk_out   = hi_p_q | (div_cur_q[0] & hi_n_q);
    assign bus.tick      = tick_q;
    assign bus.div_cur   = div_cur_q;
    assign bus.load_pend = load_pend_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: a period-level reference model checked every
// half cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_clk_div_prog;

    localparam int DIV_W   = 8;
    localparam int DIV_DEF = 5;

    logic clk;
    logic rstn;

    clk_div_prog_if #(.DIV_W(DIV_W)) bus ();

    clk_div_prog #(.DIV_W(DIV_W), .DIV_DEFAULT(DIV_DEF)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a period of N cycles is 2N half cycles, of which the first N are high.
    int m_valid = 0;
    int in_per  = 0;
    int pos     = 0;
    int n_cur   = DIV_DEF;
    int pend    = 0;
    int pend_v  = 0;
    int m_tick  = 0;
    int m_err   = 0;
    int rst_cyc = 0;

    initial begin : compare_proc
        logic s_rstn, s_en, s_load;
        int   s_div;
        forever begin
            @(posedge clk);
            s_rstn = rstn;
            s_en   = bus.en;
            s_load = bus.div_load;
            s_div  = int'(bus.div_i);
            #1;
            if (!s_rstn) begin
                m_valid = 1;
                in_per  = 0;
                pos     = 0;
                n_cur   = DIV_DEF;
                pend_v  = 0;
                m_tick  = 0;
                m_err   = 0;
                rst_cyc = 1;
            end else begin
                rst_cyc = 0;
                m_tick  = 0;
                if (in_per == 0 || pos == n_cur - 1) begin
                    if (s_en) begin
                        if (pend_v != 0) begin
                            n_cur  = pend;
                            pend_v = 0;
                        end
                        in_per = 1;
                        pos    = 0;
                        m_tick = 1;
                    end else begin
                        in_per = 0;
                    end
                end else begin
                    pos++;
                end
                m_err = 0;
                if (s_load) begin
                    if (s_div >= 2) begin
                        pend   = s_div;
                        pend_v = 1;
                    end else begin
                        m_err = 1;
                    end
                end
            end
            if (m_valid != 0) begin
                chk("tick", 32'(bus.tick), 32'(m_tick));
                chk("div_cur", 32'(bus.div_cur), 32'(n_cur));
                chk("load_pend", 32'(bus.load_pend), 32'(pend_v));
                chk("err", 32'(bus.err), 32'(m_err));
                if (rst_cyc == 0)
                    chk("clk_out_first_half", 32'(bus.clk_out), 32'(in_per != 0 && 2 * pos < n_cur));
            end
            @(negedge clk);
            #1;
            if (m_valid != 0)
                chk("clk_out_second_half", 32'(bus.clk_out), 32'(in_per != 0 && 2 * pos + 1 < n_cur));
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic load(input int v);
        bus.div_i    = DIV_W'(v);
        bus.div_load = 1'b1;
        step();
        bus.div_load = 1'b0;
    endtask

    // Waits for the next tick, then measures the high half-cycles and length of that period.
    task automatic measure(input int exp_n);
        int found, hi, per, done;
        found = 0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            #1;
            if (bus.tick === 1'b1) begin
                found = 1;
                break;
            end
        end
        chk("tick_wait", 32'(found), 32'd1);
        hi   = 0;
        per  = 0;
        done = 0;
        if (found != 0) begin
            for (int k = 0; k < 600; k++) begin
                if (bus.clk_out === 1'b1) hi++;
                @(negedge clk);
                #1;
                if (bus.clk_out === 1'b1) hi++;
                per++;
                @(posedge clk);
                #1;
                if (bus.tick === 1'b1) begin
                    done = 1;
                    break;
                end
            end
        end
        chk("period_end", 32'(done), 32'd1);
        chk("high_halves", 32'(hi), 32'(exp_n));
        chk("period_cycles", 32'(per), 32'(exp_n));
        $display("measure N=%0d: high half-cycles=%0d period=%0d cycles", exp_n, hi, per);
        #2;
    endtask

    initial begin : stimulus
        int ticks;
        rstn         = 1'b0;
        bus.en       = 1'b0;
        bus.div_i    = '0;
        bus.div_load = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
        step();
        chk("reset_div_cur", 32'(bus.div_cur), 32'd5);
        chk("reset_clk_out", 32'(bus.clk_out), 32'd0);
        chk("reset_load_pend", 32'(bus.load_pend), 32'd0);
        $display("reset released, div_cur=%0d", bus.div_cur);

        // Start from parked: rise one cycle after en is sampled.
        bus.en = 1'b1;
        step();
        chk("start_clk_out", 32'(bus.clk_out), 32'd1);
        chk("start_tick", 32'(bus.tick), 32'd1);
        measure(5);

        // Rejected loads leave everything else alone.
        load(1);
        chk("err_div1", 32'(bus.err), 32'd1);
        load(0);
        chk("err_div0", 32'(bus.err), 32'd1);
        chk("err_keeps_div", 32'(bus.div_cur), 32'd5);
        chk("err_keeps_pend", 32'(bus.load_pend), 32'd0);
        step();
        chk("err_one_cycle", 32'(bus.err), 32'd0);
        $display("rejected loads of 1 and 0");

        // Mid-period load of 4 waits for the boundary.
        measure(5);
        step();
        load(4);
        chk("pend_set", 32'(bus.load_pend), 32'd1);
        chk("pend_div_cur_old", 32'(bus.div_cur), 32'd5);
        measure(4);
        chk("applied_div_cur", 32'(bus.div_cur), 32'd4);
        chk("applied_pend_clr", 32'(bus.load_pend), 32'd0);

        // Graceful stop while high, then restart.
        bus.en = 1'b0;
        ticks  = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.tick === 1'b1) ticks++;
        end
        chk("stop_no_tick", 32'(ticks), 32'd0);
        chk("stop_clk_low", 32'(bus.clk_out), 32'd0);
        bus.en = 1'b1;
        step();
        chk("restart_clk_out", 32'(bus.clk_out), 32'd1);
        chk("restart_tick", 32'(bus.tick), 32'd1);
        $display("stop/restart done");

        // Divisor boundaries and last-writer-wins.
        load(2);   measure(2);
        load(3);   measure(3);
        load(255); measure(255);
        load(7);
        load(6);
        measure(6);

        // Reset in the middle of a high phase with a load pending.
        load(9);
        chk("pre_reset_pend", 32'(bus.load_pend), 32'd1);
        rstn   = 1'b0;
        bus.en = 1'b0;
        step();
        step();
        chk("midreset_clk_out", 32'(bus.clk_out), 32'd0);
        chk("midreset_div_cur", 32'(bus.div_cur), 32'd5);
        chk("midreset_pend", 32'(bus.load_pend), 32'd0);
        rstn = 1'b1;
        step();
        bus.en = 1'b1;
        step();
        chk("post_reset_rise", 32'(bus.clk_out), 32'd1);
        measure(5);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rstn   = ($urandom_range(0, 299) != 0);
            bus.en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 9))
                    0:       bus.div_i = DIV_W'(0);
                    1:       bus.div_i = DIV_W'(1);
                    2:       bus.div_i = DIV_W'(255);
                    default: bus.div_i = DIV_W'($urandom_range(2, 12));
                endcase
                bus.div_load = 1'b1;
            end else begin
                bus.div_load = 1'b0;
            end
            step();
        end
        bus.div_load = 1'b0;
        step();
        $display("random phase done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
